// File: rtl/vga_tim_pkg.sv
// Shared definitions for the VGA timing controller: register map, field
// positions, FSM encoding and the bundled timing record.
package vga_tim_pkg;

    localparam logic [2:0] ADR_HTIM0 = 3'd0;
    localparam logic [2:0] ADR_HTIM1 = 3'd1;
    localparam logic [2:0] ADR_VTIM0 = 3'd2;
    localparam logic [2:0] ADR_VTIM1 = 3'd3;
    localparam logic [2:0] ADR_POL   = 3'd4;

    localparam int SYNC_MSB = 31;
    localparam int SYNC_LSB = 24;
    localparam int GDEL_MSB = 23;
    localparam int GDEL_LSB = 16;
    localparam int GATE_MSB = 31;
    localparam int GATE_LSB = 16;
    localparam int LEN_MSB  = 15;
    localparam int LEN_LSB  = 0;
    localparam int POL_MSB  = 3;
    localparam int POL_LSB  = 0;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_PEND = 2'd3
    } state_t;

    // pol = {HSyncL, VSyncL, CSyncL, BlankL}
    typedef struct packed {
        logic [7:0]  hsync;
        logic [7:0]  hgdel;
        logic [15:0] hgate;
        logic [15:0] hlen;
        logic [7:0]  vsync;
        logic [7:0]  vgdel;
        logic [15:0] vgate;
        logic [15:0] vlen;
        logic [3:0]  pol;
    } timing_t;

endpackage

// File: rtl/vga_tim_chk.sv
// Limit check for one axis: the sync, back-porch and gate intervals must fit
// inside a non-zero line/frame length.
module vga_tim_chk (
    input  logic [7:0]  Tsync,
    input  logic [7:0]  Tgdel,
    input  logic [15:0] Tgate,
    input  logic [15:0] Tlen,
    output logic        err
);

    logic [16:0] w_sum;

    // 17 bits holds 255+255+65535 without wrapping
    assign w_sum = {9'd0, Tsync} + {9'd0, Tgdel} + {1'b0, Tgate};
    assign err   = (Tlen == 16'd0) || (w_sum > {1'b0, Tlen});

endmodule

// File: rtl/vga_tim_ctrl.sv
// Shadow/active timing register pair for a VGA timing generator; a commit is
// applied only at end of frame so the generator never sees a torn update.
module vga_tim_ctrl
    import vga_tim_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        we,
    input  logic [2:0]  adr,
    input  logic [31:0] dat_i,
    input  logic        commit,
    input  logic        eof,
    output logic        tgen_rst,
    output logic [7:0]  Thsync,
    output logic [7:0]  Thgdel,
    output logic [15:0] Thgate,
    output logic [15:0] Thlen,
    output logic [7:0]  Tvsync,
    output logic [7:0]  Tvgdel,
    output logic [15:0] Tvgate,
    output logic [15:0] Tvlen,
    output logic        HSyncL,
    output logic        VSyncL,
    output logic        CSyncL,
    output logic        BlankL,
    output logic        busy,
    output logic        done,
    output logic        cfg_err
);

    timing_t r_shadow;
    timing_t r_active;
    state_t  r_state;
    state_t  w_next;
    logic    r_wasLoad;
    logic    w_hErr;
    logic    w_vErr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
        end else if (we) begin
            case (adr)
                ADR_HTIM0: begin
                    r_shadow.hsync <= dat_i[SYNC_MSB:SYNC_LSB];
                    r_shadow.hgdel <= dat_i[GDEL_MSB:GDEL_LSB];
                end
                ADR_HTIM1: begin
                    r_shadow.hgate <= dat_i[GATE_MSB:GATE_LSB];
                    r_shadow.hlen  <= dat_i[LEN_MSB:LEN_LSB];
                end
                ADR_VTIM0: begin
                    r_shadow.vsync <= dat_i[SYNC_MSB:SYNC_LSB];
                    r_shadow.vgdel <= dat_i[GDEL_MSB:GDEL_LSB];
                end
                ADR_VTIM1: begin
                    r_shadow.vgate <= dat_i[GATE_MSB:GATE_LSB];
                    r_shadow.vlen  <= dat_i[LEN_MSB:LEN_LSB];
                end
                ADR_POL: r_shadow.pol <= dat_i[POL_MSB:POL_LSB];
                default: ;
            endcase
        end
    end

    // The copy uses the shadow as it was before this edge, so a write landing
    // in the LOAD cycle is not forwarded into the active set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= '0;
        end else if (r_state == ST_LOAD) begin
            r_active <= r_shadow;
        end
    end

    vga_tim_chk u_hChk (
        .Tsync (r_shadow.hsync),
        .Tgdel (r_shadow.hgdel),
        .Tgate (r_shadow.hgate),
        .Tlen  (r_shadow.hlen),
        .err   (w_hErr)
    );

    vga_tim_chk u_vChk (
        .Tsync (r_shadow.vsync),
        .Tgdel (r_shadow.vgdel),
        .Tgate (r_shadow.vgate),
        .Tlen  (r_shadow.vlen),
        .err   (w_vErr)
    );

    assign cfg_err = w_hErr | w_vErr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_OFF;
            r_wasLoad <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_wasLoad <= (r_state == ST_LOAD);
        end
    end

    // Dropping ena overrides every other transition, including a pending load.
    always_comb begin
        w_next = r_state;
        if (!ena) begin
            w_next = ST_OFF;
        end else begin
            case (r_state)
                ST_OFF:  if (!cfg_err) w_next = ST_LOAD;
                ST_LOAD: w_next = ST_RUN;
                ST_RUN:  if (commit && !cfg_err) w_next = ST_PEND;
                ST_PEND: if (eof) w_next = ST_LOAD;
                default: w_next = ST_OFF;
            endcase
        end
    end

    always_comb begin
        tgen_rst = 1'b1;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            ST_RUN: begin
                tgen_rst = 1'b0;
                done     = r_wasLoad;
            end
            ST_PEND: begin
                tgen_rst = 1'b0;
                busy     = 1'b1;
            end
            default: ;
        endcase
    end

    assign Thsync = r_active.hsync;
    assign Thgdel = r_active.hgdel;
    assign Thgate = r_active.hgate;
    assign Thlen  = r_active.hlen;
    assign Tvsync = r_active.vsync;
    assign Tvgdel = r_active.vgdel;
    assign Tvgate = r_active.vgate;
    assign Tvlen  = r_active.vlen;
    assign {HSyncL, VSyncL, CSyncL, BlankL} = r_active.pol;

endmodule

// File: tb/tb_vga_tim_ctrl.sv
// Directed bench for vga_tim_ctrl; each expected active set is queued when the
// stimulus that triggers its load is issued and checked on the done pulse.
module tb_vga_tim_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        we;
    logic [2:0]  adr;
    logic [31:0] dat_i;
    logic        commit;
    logic        eof;
    logic        tgen_rst;
    logic [7:0]  Thsync, Thgdel, Tvsync, Tvgdel;
    logic [15:0] Thgate, Thlen, Tvgate, Tvlen;
    logic        HSyncL, VSyncL, CSyncL, BlankL;
    logic        busy, done, cfg_err;

    logic [99:0] activeVec;
    logic [99:0] expQ[$];
    int          vectorsApplied = 0;
    int          miscompares = 0;

    vga_tim_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .we       (we),
        .adr      (adr),
        .dat_i    (dat_i),
        .commit   (commit),
        .eof      (eof),
        .tgen_rst (tgen_rst),
        .Thsync   (Thsync),
        .Thgdel   (Thgdel),
        .Thgate   (Thgate),
        .Thlen    (Thlen),
        .Tvsync   (Tvsync),
        .Tvgdel   (Tvgdel),
        .Tvgate   (Tvgate),
        .Tvlen    (Tvlen),
        .HSyncL   (HSyncL),
        .VSyncL   (VSyncL),
        .CSyncL   (CSyncL),
        .BlankL   (BlankL),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    assign activeVec = {Thsync, Thgdel, Thgate, Thlen, Tvsync, Tvgdel,
                        Tvgate, Tvlen, HSyncL, VSyncL, CSyncL, BlankL};

    function automatic logic [99:0] mkExp(
        input logic [7:0] hs, input logic [7:0] hg, input logic [15:0] hgate,
        input logic [15:0] hlen, input logic [7:0] vs, input logic [7:0] vg,
        input logic [15:0] vgate, input logic [15:0] vlen, input logic [3:0] pol);
        return {hs, hg, hgate, hlen, vs, vg, vgate, vlen, pol};
    endfunction

    task automatic checkOutput(input string name, input logic [99:0] act, input logic [99:0] exp);
        vectorsApplied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic applyStimulus(input logic w, input logic [2:0] a, input logic [31:0] d,
                                 input logic c, input logic e);
        we     = w;
        adr    = a;
        dat_i  = d;
        commit = c;
        eof    = e;
        tick();
        we     = 1'b0;
        commit = 1'b0;
        eof    = 1'b0;
    endtask

    task automatic writeReg(input logic [2:0] a, input logic [31:0] d);
        applyStimulus(1'b1, a, d, 1'b0, 1'b0);
    endtask

    // Every done pulse must match the oldest queued active set.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedDone", done, 0);
            end else begin
                checkOutput("doneActiveCfg", activeVec, expQ.pop_front());
                checkOutput("doneTgenRst", tgen_rst, 0);
            end
        end
    end

    initial begin
        rst = 1'b1; ena = 1'b0; we = 1'b0; adr = '0; dat_i = '0; commit = 1'b0; eof = 1'b0;
        idle(2);
        checkOutput("rstTgenRst", tgen_rst, 1);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstCfgErr", cfg_err, 1);
        checkOutput("rstActive", activeVec, 0);
        rst = 1'b0;

        // Bring-up: load the first configuration
        writeReg(3'd0, 32'h04020000);
        writeReg(3'd1, 32'h00080010);
        writeReg(3'd2, 32'h02010000);
        writeReg(3'd3, 32'h0004000A);
        writeReg(3'd4, 32'hFFFFFFF0);
        writeReg(3'd5, 32'hFFFFFFFF);
        checkOutput("offCfgOk", cfg_err, 0);
        checkOutput("offTgenRst", tgen_rst, 1);
        expQ.push_back(mkExp(8'd4, 8'd2, 16'd8, 16'd16, 8'd2, 8'd1, 16'd4, 16'd10, 4'h0));
        ena = 1'b1;
        tick();
        checkOutput("loadTgenRst", tgen_rst, 1);
        checkOutput("loadDone", done, 0);
        checkOutput("loadThlenOld", Thlen, 0);
        tick();
        checkOutput("runTgenRst", tgen_rst, 0);
        checkOutput("runThlen", Thlen, 16);
        checkOutput("runTvlen", Tvlen, 10);
        tick();
        checkOutput("doneOneCycle", done, 0);

        // Commit waits for end of frame
        writeReg(3'd1, 32'h000A0010);
        checkOutput("sumEqualLen", cfg_err, 0);
        expQ.push_back(mkExp(8'd4, 8'd2, 16'd10, 16'd16, 8'd2, 8'd1, 16'd4, 16'd10, 4'h0));
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("pendBusy", busy, 1);
        checkOutput("pendThgate", Thgate, 8);
        idle(3);
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("pendBusyHold", busy, 1);
        checkOutput("pendThgateHold", Thgate, 8);
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
        checkOutput("eofLoadBusy", busy, 0);
        checkOutput("eofLoadTgenRst", tgen_rst, 1);
        checkOutput("eofLoadThgate", Thgate, 8);
        tick();
        checkOutput("appliedThgate", Thgate, 10);
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
        tick();
        checkOutput("eofInRunBusy", busy, 0);
        checkOutput("eofInRunTgenRst", tgen_rst, 0);

        // Invalid shadow sets block commits
        writeReg(3'd1, 32'h00100010);
        checkOutput("hSumOver", cfg_err, 1);
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("badCommitBusy", busy, 0);
        checkOutput("badCommitTgenRst", tgen_rst, 0);
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
        tick();
        writeReg(3'd1, 32'h000A0010);
        checkOutput("hRestored", cfg_err, 0);
        writeReg(3'd3, 32'h0008000A);
        checkOutput("vSumOver", cfg_err, 1);
        writeReg(3'd3, 32'h0007000A);
        checkOutput("vSumEqual", cfg_err, 0);
        writeReg(3'd0, 32'hFFFF0000);
        writeReg(3'd1, 32'hFFFFFFFF);
        checkOutput("sumNoTruncate", cfg_err, 1);
        writeReg(3'd0, 32'h04020000);
        writeReg(3'd1, 32'h000A0010);

        // Simultaneous commit and eof waits for the next eof
        writeReg(3'd4, 32'h0000000A);
        expQ.push_back(mkExp(8'd4, 8'd2, 16'd10, 16'd16, 8'd2, 8'd1, 16'd7, 16'd10, 4'hA));
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b1);
        checkOutput("commitEofBusy", busy, 1);
        idle(2);
        checkOutput("commitEofWait", busy, 1);
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
        tick();
        checkOutput("polApplied", {HSyncL, VSyncL, CSyncL, BlankL}, 4'hA);

        // Disable while pending
        writeReg(3'd0, 32'h03020000);
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("pend2Busy", busy, 1);
        ena = 1'b0;
        tick();
        checkOutput("disTgenRst", tgen_rst, 1);
        checkOutput("disBusy", busy, 0);
        checkOutput("disThsyncKept", Thsync, 4);
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
        tick();
        checkOutput("disEofTgenRst", tgen_rst, 1);
        expQ.push_back(mkExp(8'd3, 8'd2, 16'd10, 16'd16, 8'd2, 8'd1, 16'd7, 16'd10, 4'hA));
        ena = 1'b1;
        idle(3);

        // Reset during a pending commit
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("pend3Busy", busy, 1);
        rst = 1'b1;
        ena = 1'b0;
        #1;
        checkOutput("asyncRstTgenRst", tgen_rst, 1);
        checkOutput("asyncRstBusy", busy, 0);
        checkOutput("asyncRstCfgErr", cfg_err, 1);
        checkOutput("asyncRstActive", activeVec, 0);
        tick();
        rst = 1'b0;
        ena = 1'b1;
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
        idle(2);
        checkOutput("postRstOff", tgen_rst, 1);
        checkOutput("postRstThlen", Thlen, 0);
        ena = 1'b0;

        // Write landing in the LOAD cycle is not forwarded
        writeReg(3'd0, 32'h04020000);
        writeReg(3'd1, 32'h00080010);
        writeReg(3'd2, 32'h02010000);
        writeReg(3'd3, 32'h0004000A);
        expQ.push_back(mkExp(8'd4, 8'd2, 16'd8, 16'd16, 8'd2, 8'd1, 16'd4, 16'd10, 4'h0));
        ena = 1'b1;
        tick();
        checkOutput("load2TgenRst", tgen_rst, 1);
        writeReg(3'd1, 32'h00080020);
        checkOutput("noForwardThlen", Thlen, 16);
        expQ.push_back(mkExp(8'd4, 8'd2, 16'd8, 16'd32, 8'd2, 8'd1, 16'd4, 16'd10, 4'h0));
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
        tick();
        checkOutput("shadowThlenLater", Thlen, 32);

        // Zero length boundaries
        writeReg(3'd0, 32'h00000000);
        writeReg(3'd1, 32'h00000000);
        checkOutput("hLenZero", cfg_err, 1);
        writeReg(3'd0, 32'h04020000);
        writeReg(3'd1, 32'h00080020);
        checkOutput("hLenRestored", cfg_err, 0);
        writeReg(3'd2, 32'h00000000);
        writeReg(3'd3, 32'h00000000);
        checkOutput("vLenZero", cfg_err, 1);

        idle(2);
        checkOutput("pendingExpects", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_tim_ctrl.md
VGA_TIM_CTRL -- requirements
Module: vga_tim_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: ena  in  1  video enable level.
REQ-004 SHALL have ports: we  in  1  shadow-register write strobe, 1-cycle.
REQ-005 SHALL have ports: adr  in  3  shadow-register address.
REQ-006 SHALL have ports: dat_i  in  32  shadow-register write data.
REQ-007 SHALL have ports: commit  in  1  1-cycle request to apply the shadow set.
REQ-008 SHALL have ports: eof  in  1  end-of-frame pulse from the timing generator.
REQ-009 SHALL have ports: tgen_rst  out  1  reset to the timing generator.
REQ-010 SHALL have ports: Thsync, Thgdel, Tvsync, Tvgdel  out  8 each  active timing values.
REQ-011 SHALL have ports: Thgate, Thlen, Tvgate, Tvlen  out  16 each  active timing values.
REQ-012 SHALL have ports: HSyncL, VSyncL, CSyncL, BlankL  out  1 each  active polarities.
REQ-013 SHALL have ports: busy  out  1  commit pending; done  out  1  1-cycle apply pulse; cfg_err  out  1  shadow set invalid.

Function
REQ-014 SHALL map shadow registers as: adr0 [31:24]=Thsync, [23:16]=Thgdel; adr1 [31:16]=Thgate, [15:0]=Thlen; adr2 [31:24]=Tvsync, [23:16]=Tvgdel; adr3 [31:16]=Tvgate, [15:0]=Tvlen; adr4 [3:0]={HSyncL,VSyncL,CSyncL,BlankL}.
REQ-015 SHALL ignore writes to adr5-7 and unused bit fields.
REQ-016 SHALL drive cfg_err combinationally high when any of the following holds on the shadow set: Thlen==0; Tvlen==0; Thsync+Thgdel+Thgate > Thlen; Tvsync+Tvgdel+Tvgate > Tvlen. The sums SHALL be evaluated at 17 bits with no truncation.
REQ-017 SHALL implement FSM states OFF, LOAD, RUN, PEND.
REQ-018 OFF: tgen_rst=1. The FSM SHALL go to LOAD when ena=1 and cfg_err=0; otherwise it SHALL stay in OFF.
REQ-019 LOAD: SHALL copy all shadow fields into the active outputs at the end of the cycle, hold tgen_rst=1, and go to RUN unconditionally. LOAD lasts exactly 1 cycle.
REQ-020 RUN: tgen_rst=0. On commit=1 with cfg_err=0, SHALL go to PEND; commit with cfg_err=1 SHALL be ignored.
REQ-021 PEND: tgen_rst=0 and busy=1. SHALL go to LOAD in the cycle following eof=1. Further commits SHALL be ignored.
REQ-022 ena=0 in any state SHALL force OFF on the next edge, with priority over all other transitions. The active values SHALL be retained.
REQ-023 done SHALL pulse for 1 cycle in the first RUN cycle after every LOAD.
REQ-024 Active values SHALL change only in LOAD, so they are never altered mid-frame.
REQ-025 A shadow write in the same cycle as LOAD SHALL update the shadow only; the active outputs take the pre-write shadow value (no forwarding).
REQ-026 Shadow writes SHALL be accepted in every state. PEND applies the shadow contents as they stand at LOAD.
REQ-027 If shadow becomes invalid while in PEND, the FSM SHALL still go to LOAD on eof.
REQ-028 eof SHALL be ignored outside PEND.
REQ-029 Simultaneous eof and commit in RUN SHALL go to PEND and wait for the next eof.

Reset
REQ-030 On rst=1, SHALL immediately set: state=OFF, tgen_rst=1, busy=0, done=0, all shadow and active registers=0.
REQ-031 cfg_err SHALL therefore be 1 while in reset, since Thlen=0.
REQ-032 Reset mid-PEND SHALL discard the pending commit.

Structure
REQ-033 Register address constants, field bit positions and state encodings SHALL live in shared package vga_tim_pkg.
REQ-034 The limit check SHALL be one sub-module, vga_tim_chk, instantiated twice (horizontal and vertical): inputs Tsync, Tgdel, Tgate, Tlen; output err.

Verification
REQ-035 Scenario: after reset, write adr0=0x04020000, adr1=0x00080010, adr2=0x02010000, adr3=0x0004000A, adr4=0x0, then ena=1 -> LOAD for 1 cycle with tgen_rst=1; next cycle Thlen=16, Tvlen=10, done=1, tgen_rst=0.
REQ-036 Scenario: in RUN, write adr1=0x000A0010 then commit -> busy=1; Thgate stays 8 until eof; the cycle after eof is LOAD; Thgate=10 in the following cycle, with done=1.
REQ-037 Scenario: write adr1=0x00100010 (4+2+16 > 16) -> cfg_err=1; commit -> state remains RUN and busy stays 0.
REQ-038 Scenario: commit, then ena=0 before eof -> OFF next cycle; tgen_rst=1; busy=0; active values unchanged.
REQ-039 Scenario: assert rst during PEND -> all outputs take their reset values immediately; a later eof produces no LOAD.
REQ-040 Scenario: we to adr1 in the same cycle as LOAD -> active Thlen equals the old shadow value; the new value appears only in the shadow.
